// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_pkg: shared scoreboard slot record, forwarding select encodings and helpers for hazard_fwd_ctrl.
// NSLOT grows to include the WB slot when HAZARD_WB_BYPASS_EN is defined.
package hazard_pkg;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  localparam int SLOT_EX = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB = 2;
`ifdef HAZARD_WB_BYPASS_EN
  localparam int NSLOT = 3;
`else
  localparam int NSLOT = 2;
`endif
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } slot_t;
  // {fsel, msel} as seen by the cascaded operand muxes
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b10,
    FWD_MEM = 2'b11
  } fwd_t;
  function automatic fwd_t fwd_pick(input logic ex_hit, input logic mem_hit);
    return ex_hit ? FWD_MEM : mem_hit ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_slot_match.sv
// hazard_slot_match: true when a source operand depends on the producer held in one scoreboard slot.
module hazard_slot_match
  import hazard_pkg::*;
(
  input  slot_t             slot,
  input  logic [REG_AW-1:0] src,
  input  logic              uses,
  output logic              hit
);
  assign hit = slot.valid & slot.reg_write & (slot.rd == src) & (src != ZERO_REG) & uses;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use stall, branch flush and registered EX-operand forwarding selects.
// Define HAZARD_WB_BYPASS_EN for a non-write-through regfile (adds fwd_a_wbsel/fwd_b_wbsel).
module hazard_fwd_ctrl #(
  parameter int REG_AW = hazard_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              fwd_a_fsel,
  output logic              fwd_a_msel,
  output logic              fwd_b_fsel,
  output logic              fwd_b_msel,
  output logic [CNT_W-1:0]  stall_count
`ifdef HAZARD_WB_BYPASS_EN
  ,
  output logic              fwd_a_wbsel,
  output logic              fwd_b_wbsel
`endif
);
  import hazard_pkg::*;
  slot_t slot [NSLOT];
  slot_t id_slot;
  logic [NSLOT-1:0][1:0] hit;
  logic load_use, transfer;
  fwd_t fwd_a, fwd_b;
  assign id_slot = {1'b1, id_rd, id_reg_write, id_mem_read};
  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    for (genvar s = 0; s < 2; s++) begin : g_src
      hazard_slot_match u_match (
        .slot (slot[g]),
        .src  (s ? id_rt : id_rs),
        .uses (s ? id_uses_rt : id_uses_rs),
        .hit  (hit[g][s])
      );
    end
  end
  assign load_use = id_valid & ~ex_branch_taken & slot[SLOT_EX].mem_read & (|hit[SLOT_EX]);
  assign transfer = id_valid & ~load_use & ~ex_branch_taken;
  assign stall = ~rst & load_use;
  assign flush_if_id = ~rst & ex_branch_taken;
  assign flush_id_ex = ~rst & ex_branch_taken;
  assign {fwd_a_fsel, fwd_a_msel} = fwd_a;
  assign {fwd_b_fsel, fwd_b_msel} = fwd_b;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) slot[i] <= '0;
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
      stall_count <= '0;
    end else begin
      for (int i = NSLOT - 1; i > 0; i--) slot[i] <= slot[i-1];
      slot[SLOT_EX] <= transfer ? id_slot : '0;
      fwd_a <= transfer ? fwd_pick(hit[SLOT_EX][0], hit[SLOT_MEM][0]) : FWD_RF;
      fwd_b <= transfer ? fwd_pick(hit[SLOT_EX][1], hit[SLOT_MEM][1]) : FWD_RF;
      if (load_use && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end
  end
`ifdef HAZARD_WB_BYPASS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_wbsel <= 1'b0;
      fwd_b_wbsel <= 1'b0;
    end else begin
      fwd_a_wbsel <= transfer & hit[SLOT_WB][0] & ~hit[SLOT_EX][0] & ~hit[SLOT_MEM][0];
      fwd_b_wbsel <= transfer & hit[SLOT_WB][1] & ~hit[SLOT_EX][1] & ~hit[SLOT_MEM][1];
    end
  end
`endif
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed test-plan sequences plus random traffic against an in-order pipeline model.
module tb_hazard_fwd_ctrl;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic id_reg_write = 1'b0, id_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic stall, flush_if_id, flush_id_ex;
  logic fwd_a_fsel, fwd_a_msel, fwd_b_fsel, fwd_b_msel;
  logic [CW-1:0] stall_count;
  hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .stall(stall), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .fwd_a_fsel(fwd_a_fsel), .fwd_a_msel(fwd_a_msel),
    .fwd_b_fsel(fwd_b_fsel), .fwd_b_msel(fwd_b_msel), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } ins_t;
  ins_t pipe[$];
  int checks = 0, passed = 0;
  int exp_fa = 0, exp_fb = 0, exp_cnt = 0;
  logic s_stall, s_fif, s_fie;
  function automatic bit hits(ins_t e, int src, bit use_it);
    return e.v && e.rw && e.rd == src && src != 0 && use_it;
  endfunction
  // youngest older instruction wins; a value still in EX will be in MEM next cycle (3), in MEM -> WB (2)
  function automatic int fwd(int src, bit use_it);
    for (int k = 0; k < 2; k++) if (hits(pipe[k], src, use_it)) return k == 0 ? 3 : 2;
    return 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic cyc();
    bit ld, tr;
    ins_t n;
    #1;
    ld = id_valid && !ex_branch_taken && pipe[0].mr &&
         (hits(pipe[0], int'(id_rs), id_uses_rs) || hits(pipe[0], int'(id_rt), id_uses_rt));
    s_stall = stall;
    s_fif = flush_if_id;
    s_fie = flush_id_ex;
    chk("stall", stall, 32'(!rst && ld));
    chk("flush_if_id", flush_if_id, 32'(!rst && ex_branch_taken));
    chk("flush_id_ex", flush_id_ex, 32'(!rst && ex_branch_taken));
    if (rst) begin
      pipe = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
      exp_fa = 0;
      exp_fb = 0;
      exp_cnt = 0;
    end else begin
      tr = id_valid && !ld && !ex_branch_taken;
      exp_fa = tr ? fwd(int'(id_rs), id_uses_rs) : 0;
      exp_fb = tr ? fwd(int'(id_rt), id_uses_rt) : 0;
      n = '{tr, tr ? int'(id_rd) : 0, tr && id_reg_write, tr && id_mem_read};
      pipe.push_front(n);
      void'(pipe.pop_back());
      if (ld && exp_cnt < (1 << CW) - 1) exp_cnt++;
    end
    @(posedge clk);
    #1;
    chk("fwd_a", {fwd_a_fsel, fwd_a_msel}, exp_fa);
    chk("fwd_b", {fwd_b_fsel, fwd_b_msel}, exp_fb);
    chk("stall_count", stall_count, exp_cnt);
  endtask
  task automatic issue(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int rd, input bit rw, input bit mr, input bit bt);
    id_valid = v;
    id_rs = 5'(rs);
    id_rt = 5'(rt);
    id_uses_rs = urs;
    id_uses_rt = urt;
    id_rd = 5'(rd);
    id_reg_write = rw;
    id_mem_read = mr;
    ex_branch_taken = bt;
    cyc();
  endtask
  initial begin
    pipe = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    rst = 1'b1;
    issue(1, 3, 3, 1, 1, 3, 1, 1, 1);
    chk("rst_fwd", {fwd_a_fsel, fwd_a_msel, fwd_b_fsel, fwd_b_msel}, 0);
    chk("rst_cnt", stall_count, 0);
    rst = 1'b0;
    issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
    issue(1, 3, 4, 1, 1, 5, 1, 0, 0);
    chk("tp1_fa", {fwd_a_fsel, fwd_a_msel}, 2'b11);
    chk("tp1_stall", s_stall, 0);
    issue(1, 1, 0, 1, 0, 3, 1, 1, 0);
    issue(1, 3, 3, 1, 1, 6, 1, 0, 0);
    chk("tp2_stall", s_stall, 1);
    chk("tp2_cnt", stall_count, 1);
    issue(1, 3, 3, 1, 1, 6, 1, 0, 0);
    chk("tp2_fwd", {fwd_a_fsel, fwd_a_msel, fwd_b_fsel, fwd_b_msel}, 4'b1010);
    issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 3, 0, 1, 1, 7, 1, 0, 0);
    chk("tp3_fwd", {fwd_a_fsel, fwd_a_msel, fwd_b_fsel, fwd_b_msel}, 4'b1000);
    issue(1, 1, 2, 1, 1, 0, 1, 0, 0);
    issue(1, 0, 0, 1, 1, 5, 1, 0, 0);
    chk("tp4_fwd", {fwd_a_fsel, fwd_a_msel, fwd_b_fsel, fwd_b_msel}, 0);
    chk("tp4_stall", s_stall, 0);
    issue(1, 1, 0, 1, 0, 3, 1, 1, 0);
    issue(1, 3, 3, 1, 1, 6, 1, 0, 1);
    chk("tp5_flush", {s_stall, s_fif, s_fie}, 3'b011);
    chk("tp5_fwd", {fwd_a_fsel, fwd_a_msel, fwd_b_fsel, fwd_b_msel}, 0);
    issue(1, 1, 0, 1, 0, 3, 1, 1, 0);
    rst = 1'b1;
    issue(1, 3, 3, 1, 1, 6, 1, 0, 0);
    chk("tp6_stall", s_stall, 0);
    chk("tp6_cnt", stall_count, 0);
    rst = 1'b0;
    issue(1, 3, 3, 1, 1, 6, 1, 0, 0);
    chk("tp6_nostall", s_stall, 0);
    for (int i = 0; i < 40; i++) issue(1, 3, 0, 1, 0, 3, 1, 1, 0);
    chk("sat_cnt", stall_count, (1 << CW) - 1);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      issue($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
